alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; all requirements below are stated for WIDTH=32.
REQ-002 elk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opA  input  32  operand A, two's-complement signed.
REQ-005 opB  input  32  operand B, two's-complement signed; ignored for NOT.
REQ-006 sel  input  3  operation select.
REQ-007 res  output  32  registered result, signed.
REQ-008 z  output  1  registered zero flag.
REQ-009 c  output  1  registered carry flag.
REQ-010 v  output  1  registered signed-overflow flag.

Function
REQ-011 Op encoding SHALL be: 000 ADD (A+B), 001 SUB (A-B), 010 AND, 011 OR, 100 NOT A (bitwise ~A), 101 XOR, 110/111 reserved.
REQ-012 Outputs SHALL be registered: opA/opB/sel sampled on a rising edge of elk appear on res/z/c/v immediately after that same edge (latency 1 cycle, one new result per cycle, no handshake).
REQ-013 Outputs SHALL hold their values between rising edges regardless of input changes.
REQ-014 ADD: 33-bit sum {c,res} = A + B (unsigned); c = bit 32 of the sum.
REQ-015 SUB: computed as A + ~B + 1; c = carry out of bit 31 (c=1 means no borrow, i.e. A >= B unsigned; 0-0 and 2-2 give c=1).
REQ-016 ADD v = (A[31]==B[31]) && (res[31]!=A[31]).
REQ-017 SUB v = (A[31]!=B[31]) && (res[31]!=A[31]).
REQ-018 z SHALL be 1 exactly when the 32-bit res being registered equals 0, for every op.
REQ-019 AND/OR/NOT/XOR SHALL register c=0, v=0.
REQ-020 Reserved sel (110,111) SHALL register res=0, z=1, c=0, v=0.
REQ-021 Results wrap modulo 2^32; no saturation.
REQ-022 Flags SHALL be computed from the same operands and op as the res registered in that cycle (no flag from previous cycle).

Reset
REQ-023 While rst=1: res=0, z=0, c=0, v=0, asynchronously on assertion, independent of elk.
REQ-024 Reset asserted mid-operation SHALL discard any result not yet registered.
REQ-025 After rst deassertion, first rising edge SHALL register the op present at that edge.

Verification
REQ-026 ADD 7 + 0xFFFFFFFE(-2) -> res=5, z=0, c=1, v=0; ADD 10+0 -> res=10, z=0, c=0, v=0.
REQ-027 ADD 0x7FFFFFFF+1 -> res=0x80000000, z=0, c=0, v=1; ADD 0xF0000000+0x80000000 -> res=0x70000000, z=0, c=1, v=1.
REQ-028 ADD -1+1 -> res=0, z=1, c=1, v=0; ADD -5+-3 -> res=-8 (0xFFFFFFF8), z=0, c=1, v=0; ADD 0+0 -> res=0, z=1, c=0, v=0.
REQ-029 SUB 10-2 -> res=8, z=0, c=1, v=0; SUB 2-2 -> res=0, z=1, c=1, v=0; SUB 0-0 -> res=0, z=1, c=1, v=0; SUB 0x80000000-1 -> res=0x7FFFFFFF, c=1, v=1.
REQ-030 AND 10&0 -> res=0, z=1; OR 15|7 -> res=15, z=0; NOT 0xFFFFFFFF -> res=0, z=1; XOR 0xF0F0F0F0^0xFFFFFFFF -> 0x0F0F0F0F; all c=0, v=0.
REQ-031 Assert rst between edges while outputs hold a nonzero result -> res/z/c/v go to 0 immediately without a clock edge; inputs changed between edges do not alter outputs until next rising edge.

Source files
------------

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- single-cycle registered arithmetic/logic unit.
//
// The operands and the op select are sampled on each rising edge of elk.
// The result and all flags are registered on that same edge. The outputs
// hold their values between edges, whatever the inputs do.
//
// Ports
//   elk  in   1      clock, rising edge
//   rst  in   1      asynchronous active-high reset; clears res/z/c/v
//   opA  in   WIDTH  operand A (two's complement)
//   opB  in   WIDTH  operand B (two's complement, unused by NOT)
//   sel  in   3      op select: ADD, SUB, AND, OR, NOT A, XOR; 110/111 reserved
//   res  out  WIDTH  registered result
//   z    out  1      registered zero flag (res == 0)
//   c    out  1      registered carry (ADD carry out, SUB no-borrow)
//   v    out  1      registered signed-overflow flag (ADD/SUB only)
// ---------------------------------------------------------------------------
module alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             elk,
   input  logic             rst,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] res,
   output logic             z,
   output logic             c,
   output logic             v
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_NOT  = 3'b100,
      OP_XOR  = 3'b101,
      OP_RSV6 = 3'b110,
      OP_RSV7 = 3'b111
   } op_t;

   op_t              op;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res_next;
   logic             c_next;
   logic             v_next;

   assign op = op_t'(sel);

   // ADD and SUB share one adder. SUB is computed as A + ~B + 1, so the
   // carry out of the top bit reads directly as "no borrow".
   always_comb begin
      addend = (op == OP_SUB) ? ~opB : opB;
      sum    = {1'b0, opA} + {1'b0, addend} + {{WIDTH{1'b0}}, (op == OP_SUB)};
   end

   always_comb begin
      res_next = '0;
      c_next   = 1'b0;
      v_next   = 1'b0;
      unique case (op)
         OP_ADD: begin
            res_next = sum[WIDTH-1:0];
            c_next   = sum[WIDTH];
            v_next   = (opA[WIDTH-1] == opB[WIDTH-1]) &&
                       (sum[WIDTH-1] != opA[WIDTH-1]);
         end
         OP_SUB: begin
            res_next = sum[WIDTH-1:0];
            c_next   = sum[WIDTH];
            v_next   = (opA[WIDTH-1] != opB[WIDTH-1]) &&
                       (sum[WIDTH-1] != opA[WIDTH-1]);
         end
         OP_AND:  res_next = opA & opB;
         OP_OR:   res_next = opA | opB;
         OP_NOT:  res_next = ~opA;
         OP_XOR:  res_next = opA ^ opB;
         OP_RSV6, OP_RSV7: res_next = '0;
         default: res_next = '0;
      endcase
   end

   always_ff @(posedge elk or posedge rst) begin
      if (rst) begin
         res <= '0;
         z   <= 1'b0;
         c   <= 1'b0;
         v   <= 1'b0;
      end else begin
         res <= res_next;
         z   <= (res_next == '0);
         c   <= c_next;
         v   <= v_next;
      end
   end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

   logic        elk = 1'b0;
   logic        rst;
   logic [31:0] opA, opB;
   logic [2:0]  sel;
   logic [31:0] res;
   logic        z, c, v;

   int checks   = 0;
   int failures = 0;

   alu #(.WIDTH(32)) dut (
      .elk(elk), .rst(rst), .opA(opA), .opB(opB), .sel(sel),
      .res(res), .z(z), .c(c), .v(v)
   );

   always #5 elk = ~elk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's meaning.
   // Packed as {res, z, c, v}.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] s);
      longint unsigned ua = {32'd0, a};
      longint unsigned ub = {32'd0, b};
      longint sa = $signed(a);
      longint sb = $signed(b);
      longint unsigned us;
      longint sr;
      logic [31:0] r = '0;
      logic cc = 1'b0;
      logic vv = 1'b0;
      case (s)
         3'd0: begin
            us = ua + ub; r = us[31:0]; cc = us[32];
            sr = sa + sb; vv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd1: begin
            r = a - b; cc = (ua >= ub);
            sr = sa - sb; vv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = ~a;
         3'd5: r = a ^ b;
         default: r = '0;
      endcase
      return {r, (r == 32'd0), cc, vv};
   endfunction

   task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] s);
      opA = a; opB = b; sel = s;
      @(posedge elk); #1;
      check(tag, {29'd0, res, z, c, v}, {29'd0, model(a, b, s)});
   endtask

   // Directed vectors with independently written expected {res,z,c,v}.
   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] s, input logic [31:0] er,
                           input logic ez, input logic ec, input logic ev);
      opA = a; opB = b; sel = s;
      @(posedge elk); #1;
      check(tag, {29'd0, res, z, c, v}, {29'd0, er, ez, ec, ev});
   endtask

   logic [31:0] ra, rb;
   logic [34:0] held;

   initial begin
      rst = 1'b1; opA = '0; opB = '0; sel = '0;
      #1;
      check("reset_state", {29'd0, res, z, c, v}, 64'd0);
      // Edges during reset must not register anything.
      opA = 32'd5; opB = 32'd6; sel = 3'd0;
      repeat (2) @(posedge elk);
      #1;
      check("reset_hold", {29'd0, res, z, c, v}, 64'd0);
      // Deassert mid-cycle; the first edge registers the op present there.
      @(negedge elk); rst = 1'b0;
      opA = 32'd3; opB = 32'd4; sel = 3'd0;
      @(posedge elk); #1;
      check("first_after_reset", {29'd0, res, z, c, v}, {29'd0, 32'd7, 1'b0, 1'b0, 1'b0});

      directed("add_7_m2",   32'd7,          32'hFFFFFFFE, 3'd0, 32'd5,          0, 1, 0);
      directed("add_10_0",   32'd10,         32'd0,        3'd0, 32'd10,         0, 0, 0);
      directed("add_max_1",  32'h7FFFFFFF,   32'd1,        3'd0, 32'h80000000,   0, 0, 1);
      directed("add_neg_ov", 32'hF0000000,   32'h80000000, 3'd0, 32'h70000000,   0, 1, 1);
      directed("add_m1_1",   32'hFFFFFFFF,   32'd1,        3'd0, 32'd0,          1, 1, 0);
      directed("add_m5_m3",  32'hFFFFFFFB,   32'hFFFFFFFD, 3'd0, 32'hFFFFFFF8,   0, 1, 0);
      directed("add_0_0",    32'd0,          32'd0,        3'd0, 32'd0,          1, 0, 0);
      directed("sub_10_2",   32'd10,         32'd2,        3'd1, 32'd8,          0, 1, 0);
      directed("sub_2_2",    32'd2,          32'd2,        3'd1, 32'd0,          1, 1, 0);
      directed("sub_0_0",    32'd0,          32'd0,        3'd1, 32'd0,          1, 1, 0);
      directed("sub_min_1",  32'h80000000,   32'd1,        3'd1, 32'h7FFFFFFF,   0, 1, 1);
      directed("sub_borrow", 32'd1,          32'd2,        3'd1, 32'hFFFFFFFF,   0, 0, 0);
      directed("and_10_0",   32'd10,         32'd0,        3'd2, 32'd0,          1, 0, 0);
      directed("or_15_7",    32'd15,         32'd7,        3'd3, 32'd15,         0, 0, 0);
      directed("not_ones",   32'hFFFFFFFF,   32'h12345678, 3'd4, 32'd0,          1, 0, 0);
      directed("xor_f0",     32'hF0F0F0F0,   32'hFFFFFFFF, 3'd5, 32'h0F0F0F0F,   0, 0, 0);
      directed("rsv_6",      32'h12345678,   32'h9ABCDEF0, 3'd6, 32'd0,          1, 0, 0);
      directed("rsv_7",      32'hFFFFFFFF,   32'hFFFFFFFF, 3'd7, 32'd0,          1, 0, 0);

      // Outputs hold between edges while inputs change.
      directed("hold_setup", 32'hFFFFFFFF,   32'hFFFFFFFF, 3'd0, 32'hFFFFFFFE,   0, 1, 0);
      opA = 32'd0; opB = 32'd0; sel = 3'd1;
      #2;
      check("hold_between_edges", {29'd0, res, z, c, v}, {29'd0, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0});

      // Asynchronous reset between edges clears immediately.
      rst = 1'b1;
      #1;
      check("async_reset", {29'd0, res, z, c, v}, 64'd0);
      @(negedge elk); rst = 1'b0;

      // Randomized, with operands biased toward corner values.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: ra = $urandom;
            1: ra = 32'h80000000 + $urandom_range(0, 2) - 1;
            2: ra = $urandom_range(0, 3);
            default: ra = 32'hFFFFFFFF - $urandom_range(0, 2);
         endcase
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = ra;
            2: rb = $urandom_range(0, 3);
            default: rb = 32'h7FFFFFFF + $urandom_range(0, 2);
         endcase
         apply("random", ra, rb, 3'($urandom_range(0, 7)));
      end

      // Reset dropped in mid-stream discards what was about to register.
      held = model(32'd1, 32'd1, 3'd0);
      opA = 32'd1; opB = 32'd1; sel = 3'd0;
      @(negedge elk); rst = 1'b1;
      @(posedge elk); #1;
      check("reset_discard", {29'd0, res, z, c, v}, 64'd0);
      @(negedge elk); rst = 1'b0;
      @(posedge elk); #1;
      check("post_reset_op", {29'd0, res, z, c, v}, {29'd0, held});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
